wb_arbiter: RTL and testbench

Register-file writeback arbiter: merges single-cycle ALU results and variable-latency memory-load results into the single write port (`we`/`wsel`/`wdata`) of the dual-reader register file. ALU results have strict priority. Load results are queued in a small FIFO and drained into idle writeback slots. A per-register busy scoreboard tells decode which registers still have a load in flight.

---
 rtl/wb_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results take the write port first, queued
// memory-load results drain into idle slots, and a busy scoreboard tracks in-flight loads.
module wb_arbiter #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  input  logic [AWIDTH-1:0]      a_sel,
  input  logic [DWIDTH-1:0]      a_data,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [AWIDTH-1:0]      m_sel,
  input  logic [DWIDTH-1:0]      m_data,
  output logic                   we,
  output logic [AWIDTH-1:0]      wsel,
  output logic [DWIDTH-1:0]      wdata,
  output logic [(2**AWIDTH)-1:0] busy,
  output logic                   err
);

  localparam int unsigned NREG = 2 ** AWIDTH;
  localparam int unsigned PW   = $clog2(DEPTH);

  typedef logic [PW:0] cnt_t;
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  logic [AWIDTH-1:0] sel_mem_q  [DEPTH];
  logic [AWIDTH-1:0] sel_mem_d  [DEPTH];
  logic [DWIDTH-1:0] data_mem_q [DEPTH];
  logic [DWIDTH-1:0] data_mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  cnt_t              count_q, count_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] wsel_q, wsel_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              wload_q, wload_d;

  logic full, empty, push, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign m_ready = rst_n && !full && !busy_q[m_sel];
  assign push    = m_valid && m_ready;
  assign pop     = !a_valid && !empty;

  always_comb begin
    sel_mem_d  = sel_mem_q;
    data_mem_d = data_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    busy_d     = busy_q;
    err_d      = err_q;
    we_d       = we_q;
    wsel_d     = wsel_q;
    wdata_d    = wdata_q;
    wload_d    = wload_q;

    // wload_q marks the current write as a drained load: its busy bit drops now,
    // on the same edge the register file captures the data.
    if (wload_q) busy_d[wsel_q] = 1'b0;

    if (push) begin
      sel_mem_d[wr_ptr_q]  = m_sel;
      data_mem_d[wr_ptr_q] = m_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
      busy_d[m_sel]        = 1'b1;
    end

    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (a_valid) begin
      we_d    = 1'b1;
      wsel_d  = a_sel;
      wdata_d = a_data;
      wload_d = 1'b0;
      if (busy_q[a_sel]) err_d = 1'b1;
    end else if (!empty) begin
      we_d    = 1'b1;
      wsel_d  = sel_mem_q[rd_ptr_q];
      wdata_d = data_mem_q[rd_ptr_q];
      wload_d = 1'b1;
    end else begin
      we_d    = 1'b0;
      wload_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sel_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      wsel_q   <= '0;
      wdata_q  <= '0;
      wload_q  <= 1'b0;
    end else begin
      sel_mem_q  <= sel_mem_d;
      data_mem_q <= data_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      we_q       <= we_d;
      wsel_q     <= wsel_d;
      wdata_q    <= wdata_d;
      wload_q    <= wload_d;
    end
  end

  assign we    = we_q;
  assign wsel  = wsel_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scenario tasks check timing inline while a
// negedge monitor matches every register-file write against ALU/load scoreboards.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [2:0]  a_sel = '0;
  logic [15:0] a_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [2:0]  m_sel = '0;
  logic [15:0] m_data = '0;
  logic        we;
  logic [2:0]  wsel;
  logic [15:0] wdata;
  logic [7:0]  busy;
  logic        err;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] data;
  } wr_t;

  wr_t  alu_q  [$];
  wr_t  load_q [$];
  wr_t  mexp;
  logic a_prev = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [2:0] regs4 [4];

  wb_arbiter #(.DWIDTH(16), .AWIDTH(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_sel(m_sel), .m_data(m_data),
    .we(we), .wsel(wsel), .wdata(wdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Whether an ALU result was presented in the cycle that just ended decides which
  // scoreboard the following write must come from.
  always @(posedge clk) a_prev <= a_valid && rst_n;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      n_checks++;
      if (a_prev) begin
        if (alu_q.size() == 0) begin
          n_fail++; $display("FAIL mon_alu_extra: got %h want no ALU write", {wsel, wdata});
        end else begin
          mexp = alu_q.pop_front();
          if ({wsel, wdata} !== mexp) begin
            n_fail++; $display("FAIL mon_alu: got %h want %h", {wsel, wdata}, mexp);
          end
        end
      end else begin
        if (load_q.size() == 0) begin
          n_fail++; $display("FAIL mon_load_extra: got %h want no load write", {wsel, wdata});
        end else begin
          mexp = load_q.pop_front();
          if ({wsel, wdata} !== mexp) begin
            n_fail++; $display("FAIL mon_load: got %h want %h", {wsel, wdata}, mexp);
          end
        end
      end
    end else if (a_prev) begin
      n_checks++; n_fail++;
      $display("FAIL mon_alu_missing: got we=%b want we=1", we);
    end
  end

  task test_reset;
    @(negedge clk);
    m_valid = 1'b1; m_sel = 3'd0;
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", we); end
    n_checks++; if (wsel !== 3'd0) begin n_fail++; $display("FAIL rst_wsel: got %h want 0", wsel); end
    n_checks++; if (wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", wdata); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL rst_busy: got %h want 00", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mready: got %b want 0", m_ready); end
    m_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task test_alu;
    @(negedge clk);
    a_valid = 1'b1; a_sel = 3'd3; a_data = 16'hBEEF;
    alu_q.push_back({3'd3, 16'hBEEF});
    @(negedge clk);
    a_valid = 1'b0;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b want 1", we); end
    n_checks++; if (wsel !== 3'd3) begin n_fail++; $display("FAIL alu_wsel: got %h want 3", wsel); end
    n_checks++; if (wdata !== 16'hBEEF) begin n_fail++; $display("FAIL alu_wdata: got %h want beef", wdata); end
    n_checks++; if (busy !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL alu_busy_err: got %h/%b want 00/0", busy, err); end
    @(negedge clk);
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL alu_we_drop: got %b want 0", we); end
    n_checks++; if (wsel !== 3'd3 || wdata !== 16'hBEEF) begin n_fail++; $display("FAIL alu_hold: got %h/%h want 3/beef", wsel, wdata); end
    n_checks++; if (busy !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL alu_busy_err2: got %h/%b want 00/0", busy, err); end
  endtask

  task test_load_latency;
    @(negedge clk);
    m_valid = 1'b1; m_sel = 3'd5; m_data = 16'h1234;
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL ld_mready: got %b want 1", m_ready); end
    load_q.push_back({3'd5, 16'h1234});
    @(negedge clk);
    m_valid = 1'b0;
    n_checks++; if (busy !== 8'h20) begin n_fail++; $display("FAIL ld_busy_set: got %h want 20", busy); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL ld_we_early: got %b want 0", we); end
    @(negedge clk);
    n_checks++; if (we !== 1'b1 || wsel !== 3'd5 || wdata !== 16'h1234) begin
      n_fail++; $display("FAIL ld_write: got %b/%h/%h want 1/5/1234", we, wsel, wdata); end
    n_checks++; if (busy !== 8'h20) begin n_fail++; $display("FAIL ld_busy_during: got %h want 20", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 8'h00 || we !== 1'b0) begin n_fail++; $display("FAIL ld_busy_clr: got %h/%b want 00/0", busy, we); end
  endtask

  task test_full;
    regs4[0] = 3'd1; regs4[1] = 3'd2; regs4[2] = 3'd4; regs4[3] = 3'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_valid = 1'b1; a_sel = 3'd0; a_data = 16'(16'hA000 + k);
      alu_q.push_back({3'd0, 16'(16'hA000 + k)});
      m_valid = 1'b1; m_sel = regs4[k]; m_data = 16'(16'h1000 + k);
      #1;
      n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL full_accept%0d: got %b want 1", k, m_ready); end
      load_q.push_back({regs4[k], 16'(16'h1000 + k)});
    end
    @(negedge clk);
    a_data = 16'hA004; alu_q.push_back({3'd0, 16'hA004});
    m_sel = 3'd7; m_data = 16'h7007;
    #1;
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL full_block: got %b want 0", m_ready); end
    n_checks++; if (busy !== 8'h56) begin n_fail++; $display("FAIL full_busy: got %h want 56", busy); end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL full_popcycle: got %b want 0", m_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL full_reassert: got %b want 1", m_ready); end
    load_q.push_back({3'd7, 16'h7007});
    n_checks++; if (we !== 1'b1 || wsel !== 3'd1) begin n_fail++; $display("FAIL full_drain0: got %b/%h want 1/1", we, wsel); end
    regs4[0] = 3'd2; regs4[1] = 3'd4; regs4[2] = 3'd6; regs4[3] = 3'd7;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_valid = 1'b0;
      n_checks++; if (we !== 1'b1 || wsel !== regs4[k]) begin
        n_fail++; $display("FAIL full_drain%0d: got %b/%h want 1/%h", k + 1, we, wsel, regs4[k]); end
    end
    @(negedge clk);
    n_checks++; if (we !== 1'b0 || busy !== 8'h00) begin n_fail++; $display("FAIL full_idle: got %b/%h want 0/00", we, busy); end
  endtask

  task test_busy_block;
    @(negedge clk);
    a_valid = 1'b1; a_sel = 3'd0; a_data = 16'hB000; alu_q.push_back({3'd0, 16'hB000});
    m_valid = 1'b1; m_sel = 3'd2; m_data = 16'h2222;
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL blk_first: got %b want 1", m_ready); end
    load_q.push_back({3'd2, 16'h2222});
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      a_data = 16'(16'hB000 + k); alu_q.push_back({3'd0, 16'(16'hB000 + k)});
      m_data = 16'h2223;
      #1;
      n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL blk_same%0d: got %b want 0", k, m_ready); end
    end
    n_checks++; if (busy !== 8'h04) begin n_fail++; $display("FAIL blk_busy: got %h want 04", busy); end
    @(negedge clk);
    a_data = 16'hB003; alu_q.push_back({3'd0, 16'hB003});
    m_sel = 3'd7; m_data = 16'h7777;
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL blk_other: got %b want 1", m_ready); end
    load_q.push_back({3'd7, 16'h7777});
    @(negedge clk);
    a_valid = 1'b0; m_sel = 3'd2; m_data = 16'h2223;
    #1;
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL blk_c4: got %b want 0", m_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL blk_c5: got %b want 0", m_ready); end
    n_checks++; if (we !== 1'b1 || wsel !== 3'd2) begin n_fail++; $display("FAIL blk_w2: got %b/%h want 1/2", we, wsel); end
    @(negedge clk);
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL blk_c6: got %b want 1", m_ready); end
    load_q.push_back({3'd2, 16'h2223});
    n_checks++; if (busy !== 8'h80 || wsel !== 3'd7) begin n_fail++; $display("FAIL blk_c6b: got %h/%h want 80/7", busy, wsel); end
    @(negedge clk);
    m_valid = 1'b0;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL blk_gap: got %b want 0", we); end
    @(negedge clk);
    n_checks++; if (we !== 1'b1 || wsel !== 3'd2 || wdata !== 16'h2223) begin
      n_fail++; $display("FAIL blk_w2b: got %b/%h/%h want 1/2/2223", we, wsel, wdata); end
    @(negedge clk);
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL blk_clr: got %h want 00", busy); end
  endtask

  task test_err;
    @(negedge clk);
    m_valid = 1'b1; m_sel = 3'd2; m_data = 16'h5A5A;
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL err_accept: got %b want 1", m_ready); end
    load_q.push_back({3'd2, 16'h5A5A});
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", err); end
    @(negedge clk);
    m_valid = 1'b0;
    a_valid = 1'b1; a_sel = 3'd2; a_data = 16'hE000; alu_q.push_back({3'd2, 16'hE000});
    n_checks++; if (busy !== 8'h04 || err !== 1'b0) begin n_fail++; $display("FAIL err_c1: got %h/%b want 04/0", busy, err); end
    @(negedge clk);
    a_valid = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    n_checks++; if (we !== 1'b1 || wsel !== 3'd2 || wdata !== 16'hE000) begin
      n_fail++; $display("FAIL err_aluw: got %b/%h/%h want 1/2/e000", we, wsel, wdata); end
    @(negedge clk);
    n_checks++; if (wsel !== 3'd2 || wdata !== 16'h5A5A || err !== 1'b1) begin
      n_fail++; $display("FAIL err_loadw: got %h/%h/%b want 2/5a5a/1", wsel, wdata, err); end
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || busy !== 8'h00) begin n_fail++; $display("FAIL err_sticky: got %b/%h want 1/00", err, busy); end
  endtask

  task test_reset_async;
    regs4[0] = 3'd3; regs4[1] = 3'd5; regs4[2] = 3'd6;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_valid = 1'b1; a_sel = 3'd0; a_data = 16'(16'hC000 + k); alu_q.push_back({3'd0, 16'(16'hC000 + k)});
      m_valid = 1'b1; m_sel = regs4[k]; m_data = 16'(16'hD000 + k);
      #1;
      n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL ar_accept%0d: got %b want 1", k, m_ready); end
      load_q.push_back({regs4[k], 16'(16'hD000 + k)});
    end
    @(negedge clk);
    a_valid = 1'b0; m_valid = 1'b0;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL ar_we_before: got %b want 1", we); end
    #2;
    rst_n = 1'b0;
    #1;
    load_q.delete();
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL ar_we: got %b want 0", we); end
    n_checks++; if (busy !== 8'h00) begin n_fail++; $display("FAIL ar_busy: got %h want 00", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", err); end
    n_checks++; if (m_ready !== 1'b0) begin n_fail++; $display("FAIL ar_mready: got %b want 0", m_ready); end
    n_checks++; if (wsel !== 3'd0 || wdata !== 16'h0) begin n_fail++; $display("FAIL ar_wout: got %h/%h want 0/0", wsel, wdata); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; m_sel = 3'd3;
    #1;
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL ar_mready_rel: got %b want 1", m_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (we !== 1'b0 || busy !== 8'h00) begin
        n_fail++; $display("FAIL ar_stale%0d: got %b/%h want 0/00", k, we, busy); end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_latency;
    test_full;
    test_busy_block;
    test_err;
    test_reset_async;
    @(negedge clk);
    n_checks++; if (alu_q.size() != 0) begin n_fail++; $display("FAIL alu_leftover: got %0d want 0", alu_q.size()); end
    n_checks++; if (load_q.size() != 0) begin n_fail++; $display("FAIL load_leftover: got %0d want 0", load_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
